// File: rtl/trail_pkg.sv
// Shared constants and the FIFO word type for the trail writeback stage.
// Packs 24-bit pixels into 32-bit slots of a 128-bit memory word.
package trail_pkg;

    localparam int PIXEL_W      = 24;
    localparam int SLOT_W       = 32;
    localparam int WORD_W       = 128;
    localparam int PIX_PER_WORD = 4;

    // Address field is carried at a fixed width so the struct does not
    // depend on the top-level ADDR_W; the top zero-extends into it.
    localparam int WB_ADDR_W = 32;

    typedef struct packed {
        logic                 last;
        logic [WB_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]    data;
    } wb_word_t;

    typedef logic [1:0] slot_t;

    // A pixel occupies the low 24 bits of its slot, upper byte zero.
    function automatic logic [SLOT_W-1:0] pixel_slot(
        input logic [PIXEL_W-1:0] pixel
    );
        return {{(SLOT_W-PIXEL_W){1'b0}}, pixel};
    endfunction

endpackage

// File: rtl/writeback_fifo.sv
// Synchronous FIFO of packed write words with a combinational head.
// Ports: clk, rst (sync, active-high), push/din/full, pop/empty/head.
import trail_pkg::*;

module writeback_fifo #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  wb_word_t din,
    output logic     full,
    input  logic     pop,
    output logic     empty,
    output wb_word_t head
);

    localparam int AW = $clog2(DEPTH);

    wb_word_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           pop_fire;
    logic           push_fire;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop_fire  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full
    // FIFO still lands when the head is leaving.
    assign push_fire = push && (!full || pop_fire);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/trail_writeback.sv
// Packs the trail IIR pixel stream into 128-bit words with frame-relative
// addresses, buffers them in a small FIFO and flags overflow/misalignment.
// Ports: clk_in, rst_in, valid_in/pixel_in/frame_start_in (pixel stream),
// wr_ready_in/wr_valid_out/wr_data_out/wr_addr_out/wr_last_out (memory),
// overflow_out, misalign_out (sticky status).
import trail_pkg::*;

module trail_writeback #(
    parameter int H_PIX      = 1280,
    parameter int V_PIX      = 720,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 18
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic                frame_start_in,
    input  logic                wr_ready_in,
    output logic                wr_valid_out,
    output logic [WORD_W-1:0]   wr_data_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic                wr_last_out,
    output logic                overflow_out,
    output logic                misalign_out
);

    localparam int WORDS_PER_FRAME = H_PIX * V_PIX / PIX_PER_WORD;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

    slot_t                        slot_q;
    logic [3*SLOT_W-1:0]          pack_q;
    logic [ADDR_W-1:0]            addr_q;
    logic                         overflow_q;
    logic                         misalign_q;

    logic                         push;
    wb_word_t                     push_word;
    logic                         fifo_full;
    logic                         fifo_empty;
    wb_word_t                     head;
    logic                         pop_fire;
    logic                         drop;
    logic                         unused_addr_bits;

    // The 4th pixel completes a word unless it restarts the frame.
    always_comb begin
        push           = 1'b0;
        push_word      = '0;
        push           = valid_in && !frame_start_in && (slot_q == 2'd3);
        push_word.data = {pixel_slot(pixel_in), pack_q};
        push_word.addr = WB_ADDR_W'(addr_q);
        push_word.last = (addr_q == LAST_ADDR);
    end

    assign pop_fire = wr_valid_out && wr_ready_in;
    assign drop     = push && fifo_full && !pop_fire;

    writeback_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (push),
        .din   (push_word),
        .full  (fifo_full),
        .pop   (wr_ready_in),
        .empty (fifo_empty),
        .head  (head)
    );

    // Outputs follow the FIFO head and read as zero when idle or in reset.
    assign wr_valid_out = !fifo_empty && !rst_in;
    assign wr_data_out  = wr_valid_out ? head.data : '0;
    assign wr_addr_out  = wr_valid_out ? head.addr[ADDR_W-1:0] : '0;
    assign wr_last_out  = wr_valid_out && head.last;
    assign overflow_out = overflow_q;
    assign misalign_out = misalign_q;

    // Upper address bits of the shared word type are always zero here.
    assign unused_addr_bits = ^head.addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q     <= '0;
            pack_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (valid_in) begin
                if (frame_start_in) begin
                    // Any partial word or non-zero position is abandoned.
                    if (slot_q != 2'd0 || addr_q != '0) begin
                        misalign_q <= 1'b1;
                    end
                    pack_q[SLOT_W-1:0] <= pixel_slot(pixel_in);
                    slot_q             <= 2'd1;
                    addr_q             <= '0;
                end else if (slot_q == 2'd3) begin
                    // Address advances even when the word was dropped.
                    slot_q <= 2'd0;
                    addr_q <= (addr_q == LAST_ADDR) ? '0
                                                    : addr_q + ADDR_W'(1);
                end else begin
                    pack_q[slot_q*SLOT_W +: SLOT_W] <= pixel_slot(pixel_in);
                    slot_q <= slot_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trail_writeback.sv
// Randomized and directed self-checking bench for trail_writeback,
// compared against a pixel-count based reference model.
module tb_trail_writeback;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 18;
    localparam int WPF   = H * V / 4;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           valid_in;
    logic [23:0]    pixel_in;
    logic           frame_start_in;
    logic           wr_ready_in;
    logic           wr_valid_out;
    logic [127:0]   wr_data_out;
    logic [AW-1:0]  wr_addr_out;
    logic           wr_last_out;
    logic           overflow_out;
    logic           misalign_out;

    trail_writeback #(
        .H_PIX      (H),
        .V_PIX      (V),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .pixel_in       (pixel_in),
        .frame_start_in (frame_start_in),
        .wr_ready_in    (wr_ready_in),
        .wr_valid_out   (wr_valid_out),
        .wr_data_out    (wr_data_out),
        .wr_addr_out    (wr_addr_out),
        .wr_last_out    (wr_last_out),
        .overflow_out   (overflow_out),
        .misalign_out   (misalign_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [127:0] data;
        int           addr;
        logic         last;
    } exp_t;

    exp_t         q[$];
    int           cnt;
    logic [23:0]  pix[4];
    logic         m_ovf;
    logic         m_mis;
    int           checks;
    int           errors;
    int           seen[$];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: position in the frame is just the pixel count since the
    // last frame start; every 4th pixel yields word (count/4 - 1).
    task automatic model_clock(input bit v, input logic [23:0] p,
                               input bit fs, input bit rdy, input bit rst);
        exp_t e;
        if (rst) begin
            q.delete();
            cnt   = 0;
            m_ovf = 1'b0;
            m_mis = 1'b0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (v) begin
                if (fs) begin
                    if (cnt != 0) m_mis = 1'b1;
                    cnt = 0;
                end
                pix[cnt % 4] = p;
                cnt++;
                if (cnt % 4 == 0) begin
                    e.data = {8'h0, pix[3], 8'h0, pix[2],
                              8'h0, pix[1], 8'h0, pix[0]};
                    e.addr = cnt / 4 - 1;
                    e.last = (e.addr == WPF - 1);
                    if (q.size() < DEPTH) q.push_back(e);
                    else m_ovf = 1'b1;
                    if (cnt == 4 * WPF) cnt = 0;
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [23:0] p, input bit fs,
                        input bit rdy, input bit rst);
        valid_in       = v;
        pixel_in       = p;
        frame_start_in = fs;
        wr_ready_in    = rdy;
        rst_in         = rst;
        if (!rst && rdy && wr_valid_out) seen.push_back(int'(wr_addr_out));
        @(posedge clk_in);
        model_clock(v, p, fs, rdy, rst);
        #1;
        check("valid", wr_valid_out, q.size() > 0);
        if (q.size() > 0) begin
            check("data", wr_data_out, q[0].data);
            check("addr", wr_addr_out, q[0].addr);
            check("last", wr_last_out, q[0].last);
        end else if (rst) begin
            check("rst_data", wr_data_out, 0);
            check("rst_addr", wr_addr_out, 0);
            check("rst_last", wr_last_out, 0);
        end
        check("overflow", overflow_out, m_ovf);
        check("misalign", misalign_out, m_mis);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
    endtask

    task automatic first_word(input string tag);
        step(1, 24'h1, 1, 1, 0);
        step(1, 24'h2, 0, 1, 0);
        step(1, 24'h3, 0, 1, 0);
        step(1, 24'h4, 0, 1, 0);
        check({tag, "_valid"}, wr_valid_out, 1);
        check({tag, "_data"}, wr_data_out,
              128'h00000004_00000003_00000002_00000001);
        check({tag, "_addr"}, wr_addr_out, 0);
        check({tag, "_last"}, wr_last_out, 0);
        step(0, 0, 0, 1, 0);
        check({tag, "_single"}, wr_valid_out, 0);
        check({tag, "_flags"}, {overflow_out, misalign_out}, 0);
    endtask

    initial begin
        int lasts;
        logic [23:0] pa;
        checks = 0;
        errors = 0;
        cnt    = 0;
        m_ovf  = 0;
        m_mis  = 0;
        valid_in = 0; pixel_in = 0; frame_start_in = 0;
        wr_ready_in = 1; rst_in = 1;

        do_reset();
        first_word("s1");

        // Full frame plus one word: wrap back to address 0.
        do_reset();
        lasts = 0;
        for (int k = 0; k < 4 * WPF + 4; k++) begin
            step(1, 24'($urandom), k == 0, 1, 0);
            if (wr_valid_out && wr_last_out) lasts++;
        end
        check("s2_lasts", lasts, 1);
        check("s2_wrap_addr", wr_addr_out, 0);
        check("s2_wrap_valid", wr_valid_out, 1);

        // Stall: four words held, fifth dropped, next word carries addr 5.
        do_reset();
        seen.delete();
        for (int k = 0; k < 20; k++) step(1, 24'($urandom), k == 0, 0, 0);
        check("s3_ovf", overflow_out, 1);
        check("s3_head", wr_addr_out, 0);
        for (int k = 0; k < 4; k++) step(1, 24'($urandom), 0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        check("s3_nseen", seen.size(), 5);
        if (seen.size() == 5) begin
            check("s3_a0", seen[0], 0);
            check("s3_a1", seen[1], 1);
            check("s3_a2", seen[2], 2);
            check("s3_a3", seen[3], 3);
            check("s3_a4", seen[4], 5);
        end

        // Frame start at slot 2 of address 1.
        do_reset();
        for (int k = 0; k < 6; k++) step(1, 24'($urandom), k == 0, 1, 0);
        check("s5_pre", misalign_out, 0);
        pa = 24'($urandom);
        step(1, pa, 1, 0, 0);
        check("s5_mis", misalign_out, 1);
        for (int k = 0; k < 3; k++) step(1, 24'($urandom), 0, 0, 0);
        check("s5_addr", wr_addr_out, 0);
        check("s5_slot0", wr_data_out[31:0], {8'h0, pa});

        // Reset with three words queued and a partial word.
        do_reset();
        for (int k = 0; k < 14; k++) step(1, 24'($urandom), k == 0, 0, 0);
        check("s6_queued", wr_valid_out, 1);
        step(1, 24'($urandom), 0, 0, 1);
        check("s6_rst_valid", wr_valid_out, 0);
        check("s6_rst_data", wr_data_out, 0);
        step(0, 0, 0, 1, 0);
        first_word("s6");

        // Random traffic.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            bit v;
            v = ($urandom_range(0, 9) < 8);
            step(v, 24'($urandom), v && ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trail_writeback.md
Name: trail_writeback

Overview:
- Downstream neighbour of the trail IIR stage: consumes its 24-bit updated-pixel stream (valid only, no backpressure) and packs pixels into 128-bit memory write words.
- Generates a frame-relative word address, so the history frame buffer can be rewritten in place for the next frame.
- Absorbs memory-side stalls with a small FIFO and reports overflow and misalignment as sticky flags.

Parameters:
- H_PIX, 1280, active pixels per line
- V_PIX, 720, active lines per frame
- FIFO_DEPTH, 4, output word FIFO depth (power of two, >= 2)
- ADDR_W, 18, word address width; must satisfy 2^ADDR_W >= H_PIX*V_PIX/4

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- valid_in  input  1  pixel_in valid this cycle
- pixel_in  input  24  updated pixel {R,G,B}
- frame_start_in  input  1  marks the first pixel of a frame; qualified by valid_in
- wr_ready_in  input  1  memory accepts the current word
- wr_valid_out  output  1  word available
- wr_data_out  output  128  packed word
- wr_addr_out  output  ADDR_W  word address within the frame buffer
- wr_last_out  output  1  word is the last of the frame (address WORDS_PER_FRAME-1)
- overflow_out  output  1  sticky: a completed word was dropped because the FIFO was full
- misalign_out  output  1  sticky: frame_start arrived with a partially packed word or mid-frame address

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, on clk_in / rst_in.
  - While rst_in is high: wr_valid_out=0, wr_data_out=0, wr_addr_out=0, wr_last_out=0, overflow_out=0, misalign_out=0.
  - Also clears slot counter, word address counter and FIFO.
  - Reset mid-word or mid-frame discards all partial state; no recovery write.
- Packing:
  - Each pixel occupies a 32-bit slot: {8'h00, pixel_in}. Slot 0 is bits [31:0], slot 3 is bits [127:96].
  - A 2-bit slot counter advances on each valid_in.
  - On the 4th pixel, the word {slot3..slot0} plus the current address is pushed to the FIFO. The address then increments, wrapping from WORDS_PER_FRAME-1 (=H_PIX*V_PIX/4-1) to 0.
  - wr_last_out is stored with the word: it is 1 exactly when that word's address equals WORDS_PER_FRAME-1.
- frame_start_in (with valid_in):
  - The slot counter and address are forced so this pixel lands in slot 0 of address 0.
  - If the slot counter was non-zero, or the address was non-zero, set misalign_out. The partially packed word is discarded.
  - The first frame_start after reset with counters at 0 does not set misalign_out.
  - frame_start_in without valid_in is ignored.
- Output handshake:
  - FIFO head drives wr_valid_out, wr_data_out, wr_addr_out and wr_last_out.
  - A word transfers on wr_valid_out && wr_ready_in.
  - Output fields are held stable while wr_valid_out=1 and wr_ready_in=0.
- Latency: with the FIFO empty and wr_ready_in=1, wr_valid_out rises on the cycle after the clock edge that captured the 4th pixel (1 cycle).
- Simultaneous push and pop:
  - Allowed in the same cycle, including when the FIFO is full: the pop frees the slot, so the push succeeds.
  - Occupancy is unchanged.
- Overflow:
  - A push when the FIFO is full and no pop occurs in that cycle drops the new word and sets overflow_out.
  - The address still increments, so later words keep correct frame positions.
- Sticky flags clear only on rst_in.
- Input stream has no stall path: valid_in may be asserted every cycle, and the block never backpressures.

Decomposition:
- Package trail_pkg:
  - constants PIXEL_W=24, SLOT_W=32, WORD_W=128, PIX_PER_WORD=4
  - typedef wb_word_t, a packed struct {last, addr, data}
- Sub-module writeback_fifo: synchronous FIFO of wb_word_t, depth FIFO_DEPTH.
  - Signals: push/full, pop/empty; head visible combinationally.
  - Pop-when-full-with-push is permitted.
- Top module: slot counter, packing register, address counter, frame_start handling, sticky flags.

Test Plan:
- Reset, then frame_start with pixels 0x000001..0x000004 on 4 consecutive cycles, wr_ready_in=1 -> one word, data=0x00000004_00000003_00000002_00000001, addr=0, last=0, wr_valid_out high 1 cycle after the 4th pixel; flags 0.
- Small frame (H_PIX=8, V_PIX=2): 16 contiguous pixels -> words at addr 0,1,2,3; wr_last_out=1 only on addr 3; a 17th pixel without frame_start goes into addr 0.
- wr_ready_in=0 for 20 cycles with continuous pixels, FIFO_DEPTH=4 -> 4 words held; the 5th completed word is dropped and overflow_out=1. On release, the words drain in order with addrs 0..3, and the next word carries addr 5.
- Hold wr_ready_in=0 while wr_valid_out=1 -> wr_data_out, wr_addr_out and wr_last_out unchanged each cycle until ready.
- frame_start after 6 pixels (slot=2, addr=1) -> misalign_out=1; partial word discarded; the new pixel is slot 0 of addr 0.
- Assert rst_in mid-word with 3 words queued -> next cycle all outputs 0 and FIFO empty; a subsequent clean frame behaves as in the first scenario.
